// File: rtl/bist_pattern_gen.sv
// ALU built-in self-test initiator: drives the fixed 8-vector pattern into the
// primary ALU and folds the golden-result checker's sticky verdict into a per-run summary.
module bist_pattern_gen #(
  parameter int DATA_W   = 32,
  parameter int INTERVAL = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              auto_en,
  input  logic              fault_detected,
  output logic              bist_active,
  output logic              test_en,
  output logic [2:0]        test_counter,
  output logic [DATA_W-1:0] test_a,
  output logic [DATA_W-1:0] test_b,
  output logic [2:0]        test_alu_ctrl,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [2:0]        fail_vector,
  output logic              fault_stale,
  output logic [7:0]        run_count
);

  localparam int                 TIMER_W    = $clog2(INTERVAL);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(INTERVAL - 1);
  localparam logic [2:0]         LAST_VEC   = 3'd7;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [2:0]        op;
  } vector_t;

  // Alternating-bit pattern; odd_set selects whether the odd bit positions are ones.
  function automatic logic [DATA_W-1:0] alt_bits(input logic odd_set);
    logic [DATA_W-1:0] pat;
    pat = '0;
    for (int i = 0; i < DATA_W; i++) begin
      pat[i] = i[0] ? odd_set : ~odd_set;
    end
    return pat;
  endfunction

  localparam logic [DATA_W-1:0] PAT_5 = alt_bits(1'b0);
  localparam logic [DATA_W-1:0] PAT_A = alt_bits(1'b1);
  localparam logic [DATA_W-1:0] ONE   = DATA_W'(1'b1);
  localparam logic [DATA_W-1:0] TWO   = DATA_W'(2'b10);

  // Stimulus ROM: both operand orders for ADD/XOR catch swapped-port faults.
  function automatic vector_t vector_for(input logic [2:0] idx);
    vector_t v;
    v.a  = PAT_5;
    v.b  = PAT_A;
    v.op = OP_ADD;
    case (idx)
      3'd0: begin v.a = PAT_5; v.b = PAT_A; v.op = OP_ADD; end
      3'd1: begin v.a = PAT_A; v.b = PAT_5; v.op = OP_ADD; end
      3'd2: begin v.a = PAT_5; v.b = PAT_A; v.op = OP_XOR; end
      3'd3: begin v.a = PAT_A; v.b = PAT_5; v.op = OP_XOR; end
      3'd4: begin v.a = PAT_5; v.b = PAT_A; v.op = OP_AND; end
      3'd5: begin v.a = PAT_5; v.b = PAT_A; v.op = OP_OR;  end
      3'd6: begin v.a = PAT_A; v.b = PAT_5; v.op = OP_SUB; end
      3'd7: begin v.a = ONE;   v.b = TWO;   v.op = OP_SLT; end
      default: begin v.a = PAT_5; v.b = PAT_A; v.op = OP_ADD; end
    endcase
    return v;
  endfunction

  state_t             state_r, state_s;
  logic [2:0]         cnt_r, cnt_s;
  logic [TIMER_W-1:0] timer_r, timer_s;
  logic               go_s;

  logic               stale_r;
  logic               cap_valid_r;
  logic [2:0]         cap_idx_r;
  logic               cap_hit_s;
  logic [2:0]         cap_idx_s;
  logic [2:0]         final_fail_s;
  logic [7:0]         run_count_s;

  vector_t            vec_s;
  logic               bist_active_s, test_en_s, busy_s, done_s;
  logic [2:0]         test_counter_s, test_alu_ctrl_s;
  logic [DATA_W-1:0]  test_a_s, test_b_s;

  logic               bist_active_r, test_en_r, busy_r, done_r;
  logic [2:0]         test_counter_r, test_alu_ctrl_r;
  logic [DATA_W-1:0]  test_a_r, test_b_r;
  logic               pass_r, fault_stale_r;
  logic [2:0]         fail_vector_r;
  logic [7:0]         run_count_r;

  // State, vector index and auto-test timer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
      cnt_r   <= 3'd0;
      timer_r <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      timer_r <= timer_s;
    end
  end

  // Next-state, vector index and timer logic; start is only honoured in IDLE.
  always_comb begin
    go_s    = (state_r == S_IDLE) && (start || (auto_en && (timer_r == TIMER_LAST)));
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      S_IDLE: begin
        cnt_s = 3'd0;
        if (go_s) state_s = S_RUN;
        else      state_s = S_IDLE;
      end
      S_RUN: begin
        if (cnt_r == LAST_VEC) begin
          state_s = S_CHECK;
        end else begin
          state_s = S_RUN;
          cnt_s   = cnt_r + 3'd1;
        end
      end
      S_CHECK: state_s = S_DONE;
      S_DONE:  state_s = S_IDLE;
      default: begin
        state_s = S_IDLE;
        cnt_s   = 3'd0;
      end
    endcase
    if ((state_r == S_IDLE) && auto_en && !go_s) timer_s = timer_r + TIMER_W'(1'b1);
    else                                         timer_s = '0;
  end

  // The checker's verdict lags one cycle, so a fault seen now belongs to the previous vector.
  always_comb begin
    cap_idx_s = (state_r == S_CHECK) ? LAST_VEC : (cnt_r - 3'd1);
    cap_hit_s = fault_detected && !stale_r && !cap_valid_r &&
                (((state_r == S_RUN) && (cnt_r != 3'd0)) || (state_r == S_CHECK));
    if (stale_r)          final_fail_s = 3'd0;
    else if (cap_valid_r) final_fail_s = cap_idx_r;
    else if (cap_hit_s)   final_fail_s = cap_idx_s;
    else                  final_fail_s = 3'd0;
    run_count_s = (run_count_r == 8'd255) ? run_count_r : (run_count_r + 8'd1);
  end

  // Per-run stale flag and first-failure capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stale_r     <= 1'b0;
      cap_valid_r <= 1'b0;
      cap_idx_r   <= 3'd0;
    end else if (go_s) begin
      stale_r     <= fault_detected;
      cap_valid_r <= 1'b0;
      cap_idx_r   <= 3'd0;
    end else if (cap_hit_s) begin
      cap_valid_r <= 1'b1;
      cap_idx_r   <= cap_idx_s;
    end else begin
      cap_valid_r <= cap_valid_r;
    end
  end

  // Output decode from the upcoming state so the registered outputs line up with it.
  always_comb begin
    vec_s           = vector_for((state_s == S_CHECK) ? LAST_VEC : cnt_s);
    bist_active_s   = 1'b0;
    test_en_s       = 1'b0;
    test_counter_s  = 3'd0;
    test_a_s        = '0;
    test_b_s        = '0;
    test_alu_ctrl_s = 3'd0;
    busy_s          = (state_s != S_IDLE);
    done_s          = (state_s == S_DONE);
    case (state_s)
      S_RUN: begin
        bist_active_s   = 1'b1;
        test_en_s       = 1'b1;
        test_counter_s  = cnt_s;
        test_a_s        = vec_s.a;
        test_b_s        = vec_s.b;
        test_alu_ctrl_s = vec_s.op;
      end
      S_CHECK: begin
        bist_active_s   = 1'b1;
        test_counter_s  = LAST_VEC;
        test_a_s        = vec_s.a;
        test_b_s        = vec_s.b;
        test_alu_ctrl_s = vec_s.op;
      end
      S_IDLE, S_DONE: begin
        bist_active_s = 1'b0;
      end
      default: begin
        bist_active_s = 1'b0;
      end
    endcase
  end

  // Registered test-drive outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bist_active_r   <= 1'b0;
      test_en_r       <= 1'b0;
      test_counter_r  <= 3'd0;
      test_a_r        <= '0;
      test_b_r        <= '0;
      test_alu_ctrl_r <= 3'd0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
    end else begin
      bist_active_r   <= bist_active_s;
      test_en_r       <= test_en_s;
      test_counter_r  <= test_counter_s;
      test_a_r        <= test_a_s;
      test_b_r        <= test_b_s;
      test_alu_ctrl_r <= test_alu_ctrl_s;
      busy_r          <= busy_s;
      done_r          <= done_s;
    end
  end

  // Run summary is committed on entry to DONE so it is valid alongside the done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pass_r        <= 1'b0;
      fault_stale_r <= 1'b0;
      fail_vector_r <= 3'd0;
      run_count_r   <= 8'd0;
    end else if (state_r == S_CHECK) begin
      pass_r        <= ~fault_detected;
      fault_stale_r <= stale_r;
      fail_vector_r <= final_fail_s;
      run_count_r   <= run_count_s;
    end else begin
      pass_r        <= pass_r;
    end
  end

  assign bist_active   = bist_active_r;
  assign test_en       = test_en_r;
  assign test_counter  = test_counter_r;
  assign test_a        = test_a_r;
  assign test_b        = test_b_r;
  assign test_alu_ctrl = test_alu_ctrl_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign pass          = pass_r;
  assign fail_vector   = fail_vector_r;
  assign fault_stale   = fault_stale_r;
  assign run_count     = run_count_r;

endmodule

// File: tb/tb_bist_pattern_gen.sv
// Bench for bist_pattern_gen: a behavioural ALU with injectable stuck-at-0 faults
// and a sticky golden-result checker surround the DUT; expectations come from the vector table.
module tb_bist_pattern_gen;
  localparam int DATA_W   = 32;
  localparam int INTERVAL = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, start, auto_en, fault_detected;
  logic              bist_active, test_en, busy, done, pass, fault_stale;
  logic [2:0]        test_counter, test_alu_ctrl, fail_vector;
  logic [DATA_W-1:0] test_a, test_b;
  logic [7:0]        run_count;

  bist_pattern_gen #(.DATA_W(DATA_W), .INTERVAL(INTERVAL)) dut (
    .clk(clk), .rst(rst), .start(start), .auto_en(auto_en),
    .fault_detected(fault_detected), .bist_active(bist_active), .test_en(test_en),
    .test_counter(test_counter), .test_a(test_a), .test_b(test_b),
    .test_alu_ctrl(test_alu_ctrl), .busy(busy), .done(done), .pass(pass),
    .fail_vector(fail_vector), .fault_stale(fault_stale), .run_count(run_count)
  );

  int checks = 0;
  int errors = 0;
  int exp_runs = 0;
  int done_seen = 0;

  logic [31:0] tab_a [8];
  logic [31:0] tab_b [8];
  logic [2:0]  tab_op[8];

  logic flt_en, chk_clear, chk_force;
  logic [2:0] flt_op;
  int flt_bit;

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] alu_dut(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = alu_ref(op, a, b);
    if (flt_en && op == flt_op) r[flt_bit] = 1'b0;
    return r;
  endfunction

  function automatic int first_fail();
    for (int k = 0; k < 8; k++)
      if (alu_dut(tab_op[k], tab_a[k], tab_b[k]) !== alu_ref(tab_op[k], tab_a[k], tab_b[k])) return k;
    return -1;
  endfunction

  // Golden-result checker: compares the (possibly faulty) ALU result with the table, sticky.
  always @(posedge clk) begin
    if (chk_clear) fault_detected <= 1'b0;
    else if (chk_force) fault_detected <= 1'b1;
    else if (test_en === 1'b1 &&
             alu_dut(test_alu_ctrl, test_a, test_b) !== alu_ref(tab_op[test_counter], tab_a[test_counter], tab_b[test_counter]))
      fault_detected <= 1'b1;
  end

  always @(posedge clk) if (done === 1'b1) done_seen <= done_seen + 1;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_checker();
    chk_clear = 1'b1; tick(); chk_clear = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " bist_active"}, bist_active, 0);
    chk({tag, " test_en"}, test_en, 0);
    chk({tag, " test_counter"}, test_counter, 0);
    chk({tag, " test_a"}, test_a, 0);
    chk({tag, " test_b"}, test_b, 0);
    chk({tag, " alu_ctrl"}, test_alu_ctrl, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " pass"}, pass, 0);
    chk({tag, " fail_vector"}, fail_vector, 0);
    chk({tag, " fault_stale"}, fault_stale, 0);
    chk({tag, " run_count"}, run_count, 0);
  endtask

  task automatic run_and_check(input string tag, input bit stale, input bit pulse_mid);
    int fk, d0;
    logic exp_pass;
    logic [2:0] exp_fv;
    fk = first_fail();
    exp_pass = !stale && (fk < 0);
    exp_fv = (stale || fk < 0) ? 3'd0 : 3'(fk);
    exp_runs = (exp_runs < 255) ? exp_runs + 1 : 255;
    d0 = done_seen;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk({tag, " run test_en"}, test_en, 1);
      chk({tag, " run counter"}, test_counter, k);
      chk({tag, " run test_a"}, test_a, tab_a[k]);
      chk({tag, " run test_b"}, test_b, tab_b[k]);
      chk({tag, " run alu_ctrl"}, test_alu_ctrl, tab_op[k]);
      chk({tag, " run bist_active"}, bist_active, 1);
      chk({tag, " run busy"}, busy, 1);
      start = (pulse_mid && (k == 3 || k == 6)) ? 1'b1 : 1'b0;
      tick();
    end
    start = 1'b0;
    chk({tag, " check test_en"}, test_en, 0);
    chk({tag, " check bist_active"}, bist_active, 1);
    chk({tag, " check counter"}, test_counter, 7);
    chk({tag, " check test_a"}, test_a, tab_a[7]);
    chk({tag, " check done"}, done, 0);
    tick();
    chk({tag, " done pulse"}, done, 1);
    chk({tag, " done bist_active"}, bist_active, 0);
    chk({tag, " done busy"}, busy, 1);
    chk({tag, " pass"}, pass, exp_pass);
    chk({tag, " fail_vector"}, fail_vector, exp_fv);
    chk({tag, " fault_stale"}, fault_stale, stale);
    chk({tag, " run_count"}, run_count, exp_runs);
    tick();
    chk({tag, " idle done"}, done, 0);
    chk({tag, " idle busy"}, busy, 0);
    chk({tag, " idle test_a"}, test_a, 0);
    chk({tag, " held pass"}, pass, exp_pass);
    chk({tag, " held fail_vector"}, fail_vector, exp_fv);
    chk({tag, " done count"}, done_seen - d0, 1);
  endtask

  initial begin
    int n, d0;
    bit seen_low;
    for (int k = 0; k < 8; k++) begin
      tab_a[k] = (k == 1 || k == 3 || k == 6) ? 32'hAAAAAAAA : 32'h55555555;
      tab_b[k] = (k == 1 || k == 3 || k == 6) ? 32'h55555555 : 32'hAAAAAAAA;
    end
    tab_a[7] = 32'd1; tab_b[7] = 32'd2;
    tab_op[0] = 3'd0; tab_op[1] = 3'd0; tab_op[2] = 3'd4; tab_op[3] = 3'd4;
    tab_op[4] = 3'd2; tab_op[5] = 3'd3; tab_op[6] = 3'd1; tab_op[7] = 3'd5;

    rst = 1'b0; start = 1'b0; auto_en = 1'b0;
    chk_clear = 1'b1; chk_force = 1'b0;
    flt_en = 1'b0; flt_op = 3'd0; flt_bit = 0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b1; chk_clear = 1'b0;
    tick();
    chk_all_zero("post reset idle");

    run_and_check("clean", 1'b0, 1'b0);

    flt_en = 1'b1; flt_op = 3'd2; flt_bit = 0; clear_checker();
    run_and_check("and bit0 stuck", 1'b0, 1'b0);

    flt_op = 3'd3; clear_checker();
    run_and_check("or bit0 stuck", 1'b0, 1'b0);
    chk("or fail index", fail_vector, 5);

    flt_en = 1'b0; clear_checker();
    run_and_check("start while busy", 1'b0, 1'b1);
    repeat (5) tick();
    chk("no queued run", busy, 0);

    chk_force = 1'b1; tick(); chk_force = 1'b0;
    run_and_check("stale fault", 1'b1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      flt_en = ($urandom_range(0, 3) != 0);
      flt_op = 3'($urandom_range(0, 5));
      flt_bit = $urandom_range(0, 31);
      repeat ($urandom_range(0, 5)) tick();
      clear_checker();
      run_and_check("random fault", 1'b0, 1'b0);
    end

    flt_en = 1'b0; clear_checker();
    auto_en = 1'b1; n = 0;
    while (bist_active !== 1'b1 && n < 100) begin tick(); n++; end
    chk("auto first delay", n, INTERVAL);
    n = 0; seen_low = 1'b0;
    while (n < 100 && !(seen_low && bist_active === 1'b1)) begin
      tick(); n++;
      if (bist_active === 1'b0) seen_low = 1'b1;
    end
    chk("auto period", n, INTERVAL + 10);
    repeat (INTERVAL + 9) tick();
    start = 1'b1; tick(); start = 1'b0;
    chk("timer hit run", bist_active, 1);
    d0 = done_seen;
    repeat (10) tick();
    chk("timer hit single done", done_seen - d0, 1);
    chk("timer hit idle", busy, 0);
    exp_runs += 3;
    chk("auto run_count", run_count, exp_runs);
    auto_en = 1'b0;
    repeat (40) tick();
    chk("auto off", bist_active, 0);

    clear_checker();
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    chk("pre reset counter", test_counter, 4);
    rst = 1'b0;
    #1;
    chk_all_zero("mid-run reset");
    d0 = done_seen;
    tick();
    chk("no done on abort", done_seen - d0, 0);
    rst = 1'b1; exp_runs = 0;
    run_and_check("after abort", 1'b0, 1'b0);

    while (exp_runs < 255) begin
      start = 1'b1; tick(); start = 1'b0;
      repeat (10) tick();
      exp_runs++;
    end
    chk("run_count at 255", run_count, 255);
    run_and_check("saturated", 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
